// File: rtl/pause_fader.sv
// ============================================================================
//  Module   : pause_fader
//  Brief    : Merges pause sources into one registered CPU pause and dims the
//             RGB stream after a long pause. Build macro: PAUSE_FRAME_SYNC_EN
//             (defined = pause entry/exit waits for a rising vblank edge).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pause_fader #(
    parameter int          RW          = 8,
    parameter int          GW          = 8,
    parameter int          BW          = 8,
    parameter int          CLKSPD      = 12,
    parameter int          NREQ        = 2,
    parameter logic [31:0] DIM_CYCLES  = 32'(CLKSPD * 10000000),
    parameter logic [31:0] STEP_CYCLES = 32'(CLKSPD * 500000),
    parameter int          DIM_LEVELS  = 2
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  user_button,
    input  logic [NREQ-1:0]       pause_request,
    input  logic [1:0]            options,
    input  logic                  OSD_STATUS,
    input  logic                  vblank,
    input  logic [RW-1:0]         r,
    input  logic [GW-1:0]         g,
    input  logic [BW-1:0]         b,
    output logic                  pause_cpu,
    output logic [1:0]            dim_level,
    output logic [RW+GW+BW-1:0]   rgb_out
);

    localparam logic [1:0] c_max_level = 2'(DIM_LEVELS);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_PEND   = 2'd1,
        S_PAUSED = 2'd2,
        S_RESUME = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_btn_q;
    logic        r_toggle;
    logic        r_pause_cpu;
    logic [1:0]  r_dim_level;
    logic [31:0] r_dim_cnt;
    logic [31:0] r_step_cnt;
    logic        w_btn_rise;
    logic        w_want;
    logic        w_dim_active;

    assign w_btn_rise = user_button & ~r_btn_q;
    assign w_want     = (|pause_request) | r_toggle | (OSD_STATUS & options[0]);

`ifdef PAUSE_FRAME_SYNC_EN
    logic r_vblank_q;
    logic w_vb_edge;

    assign w_vb_edge = vblank & ~r_vblank_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_vblank_q <= 1'b0;
        else          r_vblank_q <= vblank;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:    if (w_want) w_state_nxt = S_PEND;
            // A same-cycle request drop beats the vblank edge
            S_PEND:   if (!w_want)        w_state_nxt = S_RUN;
                      else if (w_vb_edge) w_state_nxt = S_PAUSED;
            S_PAUSED: if (!w_want) w_state_nxt = S_RESUME;
            S_RESUME: if (w_want)         w_state_nxt = S_PAUSED;
                      else if (w_vb_edge) w_state_nxt = S_RUN;
            default:  w_state_nxt = S_RUN;
        endcase
    end
`else
    logic w_unused_vblank;
    assign w_unused_vblank = vblank;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:    if (w_want)  w_state_nxt = S_PAUSED;
            S_PAUSED: if (!w_want) w_state_nxt = S_RUN;
            default:  w_state_nxt = S_RUN;
        endcase
    end
`endif

    // pause_cpu is registered from the next state so it tracks the state register exactly
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_RUN;
            r_btn_q     <= 1'b0;
            r_toggle    <= 1'b0;
            r_pause_cpu <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_btn_q     <= user_button;
            r_toggle    <= r_toggle ^ w_btn_rise;
            r_pause_cpu <= (w_state_nxt == S_PAUSED) || (w_state_nxt == S_RESUME);
        end
    end

    assign w_dim_active = ((r_state == S_PAUSED) || (r_state == S_RESUME)) && options[1];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_dim_level <= 2'd0;
            r_dim_cnt   <= 32'd0;
            r_step_cnt  <= 32'd0;
        end else if (!w_dim_active) begin
            r_dim_level <= 2'd0;
            r_dim_cnt   <= 32'd0;
            r_step_cnt  <= 32'd0;
        end else if (r_dim_level == 2'd0) begin
            if (r_dim_cnt == DIM_CYCLES - 32'd1) r_dim_level <= 2'd1;
            else                                 r_dim_cnt   <= r_dim_cnt + 32'd1;
        end else if (r_dim_level < c_max_level) begin
            if (r_step_cnt == STEP_CYCLES - 32'd1) begin
                r_step_cnt  <= 32'd0;
                r_dim_level <= r_dim_level + 2'd1;
            end else begin
                r_step_cnt  <= r_step_cnt + 32'd1;
            end
        end
    end

    assign pause_cpu = r_pause_cpu;
    assign dim_level = r_dim_level;
    assign rgb_out   = {r >> r_dim_level, g >> r_dim_level, b >> r_dim_level};

endmodule

`default_nettype wire

// File: tb/tb_pause_fader.sv
// ============================================================================
//  Module   : tb_pause_fader
//  Brief    : Self-checking bench for pause_fader against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pause_fader;

    localparam int          NREQ  = 2;
    localparam logic [31:0] DIMC  = 32'd100;
    localparam logic [31:0] STEPC = 32'd10;
    localparam int          DL    = 2;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        user_button = 1'b0;
    logic [1:0]  pause_request = 2'b00;
    logic [1:0]  options = 2'b00;
    logic        OSD_STATUS = 1'b0;
    logic        vblank = 1'b0;
    logic [7:0]  r = 8'h00, g = 8'h00, b = 8'h00;
    logic        pause_cpu;
    logic [1:0]  dim_level;
    logic [23:0] rgb_out;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model state
    bit m_toggle, m_btn_prev, m_vb_prev, m_paused, m_armed;
    int m_paused_cycles;

    typedef struct {
        logic [7:0]  r, g, b;
        logic [23:0] exp;
    } pix_vec_t;
    pix_vec_t pix_tab [4];

    pause_fader #(
        .RW(8), .GW(8), .BW(8), .CLKSPD(12), .NREQ(NREQ),
        .DIM_CYCLES(DIMC), .STEP_CYCLES(STEPC), .DIM_LEVELS(DL)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .user_button(user_button),
        .pause_request(pause_request), .options(options), .OSD_STATUS(OSD_STATUS),
        .vblank(vblank), .r(r), .g(g), .b(b),
        .pause_cpu(pause_cpu), .dim_level(dim_level), .rgb_out(rgb_out)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_dim();
        int d;
        if (m_paused_cycles < int'(DIMC)) return 0;
        d = 1 + (m_paused_cycles - int'(DIMC)) / int'(STEPC);
        return (d > DL) ? DL : d;
    endfunction

    task automatic chk_all(input string tag);
        int d;
        d = exp_dim();
        chk({tag, ".pause_cpu"}, {31'd0, pause_cpu}, {31'd0, m_paused});
        chk({tag, ".dim_level"}, {30'd0, dim_level}, d);
        chk({tag, ".rgb_out"}, {8'd0, rgb_out}, {8'd0, r >> d, g >> d, b >> d});
    endtask

    task automatic model_reset();
        m_toggle = 0; m_btn_prev = 0; m_vb_prev = 0;
        m_paused = 0; m_armed = 0; m_paused_cycles = 0;
    endtask

    // advance the model by one clock using the inputs present before the edge
    task automatic step();
        bit want, vbr, rise, old_p, old_a;
        rise  = user_button && !m_btn_prev;
        vbr   = vblank && !m_vb_prev;
        want  = (|pause_request) || m_toggle || (OSD_STATUS && options[0]);
        old_p = m_paused;
        old_a = m_armed;
        if (old_p && options[1]) m_paused_cycles++;
        else                     m_paused_cycles = 0;
`ifdef PAUSE_FRAME_SYNC_EN
        if (!old_p) begin
            if (old_a && want && vbr) begin m_paused = 1; m_armed = 0; end
            else m_armed = want;
        end else begin
            if (old_a && !want && vbr) begin m_paused = 0; m_armed = 0; end
            else m_armed = !want;
        end
`else
        m_paused = want;
`endif
        m_toggle   = m_toggle ^ rise;
        m_btn_prev = user_button;
        m_vb_prev  = vblank;
        @(posedge clk_sys);
        #1;
        chk_all("step");
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk_sys);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk({tag, ".pause_cpu"}, {31'd0, pause_cpu}, 32'd0);
        chk({tag, ".dim_level"}, {30'd0, dim_level}, 32'd0);
        chk({tag, ".rgb_out"}, {8'd0, rgb_out}, {8'd0, r, g, b});
        @(negedge clk_sys);
        reset_n = 1'b1;
    endtask

    task automatic button_press();
        user_button = 1'b1; step();
        user_button = 1'b0; step();
`ifdef PAUSE_FRAME_SYNC_EN
        vblank = 1'b1; step();
        vblank = 1'b0;
`endif
    endtask

    initial begin
        pix_tab[0] = '{8'hFF, 8'h80, 8'h03, 24'h3F2000};
        pix_tab[1] = '{8'h12, 8'h34, 8'h56, 24'h040D15};
        pix_tab[2] = '{8'h01, 8'h7F, 8'hC8, 24'h001F32};
        pix_tab[3] = '{8'hFF, 8'hFF, 8'hFF, 24'h3F3F3F};

        model_reset();
        r = 8'hFF; g = 8'hFF; b = 8'hFF;
        async_reset("reset");

        // dimming ramp from a button pause
        options = 2'b10;
        button_press();
        chk("paused", {31'd0, pause_cpu}, 32'd1);
        repeat (99) step();
        chk("dim.before", {8'd0, rgb_out}, 32'h00FFFFFF);
        step();
        chk("dim.first", {8'd0, rgb_out}, 32'h007F7F7F);
        repeat (10) step();
        chk("dim.second", {8'd0, rgb_out}, 32'h003F3F3F);
        repeat (20) step();
        chk("dim.sat", {8'd0, rgb_out}, 32'h003F3F3F);

        for (int i = 0; i < 4; i++) begin
            r = pix_tab[i].r; g = pix_tab[i].g; b = pix_tab[i].b;
            #1;
            chk($sformatf("pix[%0d]", i), {8'd0, rgb_out}, {8'd0, pix_tab[i].exp});
        end
        r = 8'hFF; g = 8'hFF; b = 8'hFF;

        // dim disable clears immediately, then restarts from zero
        options = 2'b00; step();
        chk("dimoff", {30'd0, dim_level}, 32'd0);
        options = 2'b10; step();
        chk("dimrestart", {30'd0, dim_level}, 32'd0);
        button_press();
        chk("resumed", {31'd0, pause_cpu}, 32'd0);

        // async reset while paused and dimmed
        button_press();
        repeat (105) step();
        chk("predim", {30'd0, dim_level}, 32'd1);
        async_reset("midreset");
        step();

`ifdef PAUSE_FRAME_SYNC_EN
        pause_request = 2'b01;
        repeat (5) step();
        chk("sync.wait", {31'd0, pause_cpu}, 32'd0);
        vblank = 1'b1; step(); vblank = 1'b0;
        chk("sync.enter", {31'd0, pause_cpu}, 32'd1);
        pause_request = 2'b00;
        repeat (5) step();
        chk("sync.hold", {31'd0, pause_cpu}, 32'd1);
        vblank = 1'b1; step(); vblank = 1'b0;
        chk("sync.exit", {31'd0, pause_cpu}, 32'd0);
        step();
        pause_request = 2'b10;
        repeat (5) step();
        pause_request = 2'b00;
        step();
        vblank = 1'b1; step(); vblank = 1'b0;
        chk("sync.pulse", {31'd0, pause_cpu}, 32'd0);
        step();
`else
        options = 2'b01; OSD_STATUS = 1'b1; user_button = 1'b1;
        step();
        chk("osd.pause", {31'd0, pause_cpu}, 32'd1);
        OSD_STATUS = 1'b0; user_button = 1'b0;
        repeat (3) step();
        chk("osd.held", {31'd0, pause_cpu}, 32'd1);
        button_press(); step();
        chk("osd.release", {31'd0, pause_cpu}, 32'd0);
`endif

        // randomized traffic against the model
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 49) == 0)  pause_request = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0)  OSD_STATUS = ~OSD_STATUS;
            if ($urandom_range(0, 199) == 0) options = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1))};
            user_button = ($urandom_range(0, 79) == 0);
            vblank = ((cyc % 60) >= 55);
            r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
            if (cyc == 2500) async_reset("rnd.reset");
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
